pipelined_addsub: RTL and testbench

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/pipelined_addsub.sv | 117 +++++++++++
 tb/tb_pipelined_addsub.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Segmented carry-ripple adder/subtractor: STAGES=WIDTH/SEG registered stages with valid/ready flow control.
// Optional signed-overflow output enabled by defining PIPELINED_ADDSUB_OVF_EN.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPELINED_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH % SEG) != 0 || SEG < 1) begin : g_bad_param
        $error("pipelined_addsub: WIDTH must be a positive multiple of SEG");
    end

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];

    logic              w_advance;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_cin;
    logic [WIDTH-1:0]  w_op_a [STAGES];
    logic [WIDTH-1:0]  w_op_b [STAGES];
    logic [WIDTH-1:0]  w_psum [STAGES];
    logic [SEG:0]      w_seg  [STAGES];

    assign w_advance = ~r_valid[LAST] | out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_valid[LAST];
    assign sum       = r_sum[LAST];
    assign c_out     = r_carry[LAST];

    // Stage operand selection and per-segment add; subtraction folds into stage 0 as a + ~b + 1.
    always_comb begin
        w_vin[0]  = in_valid;
        w_cin[0]  = sub ? 1'b1 : c_in;
        w_op_a[0] = a;
        w_op_b[0] = sub ? ~b : b;
        w_psum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k]  = r_valid[k-1];
            w_cin[k]  = r_carry[k-1];
            w_op_a[k] = r_a[k-1];
            w_op_b[k] = r_b[k-1];
            w_psum[k] = r_sum[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_op_a[k][k*SEG +: SEG]}
                     + {1'b0, w_op_b[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_cin[k]};
        end
    end

    // Pipeline registers: the whole pipe shifts together on advance and holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k]               <= w_vin[k];
                r_carry[k]               <= w_seg[k][SEG];
                r_a[k]                   <= w_op_a[k];
                r_b[k]                   <= w_op_b[k];
                r_sum[k]                 <= w_psum[k];
                r_sum[k][k*SEG +: SEG]   <= w_seg[k][SEG-1:0];
            end
        end
    end

`ifdef PIPELINED_ADDSUB_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Signed overflow: operands share a sign that differs from the result sign.
    always_comb begin
        w_ovf = (w_op_a[LAST][WIDTH-1] == w_op_b[LAST][WIDTH-1])
              && (w_seg[LAST][SEG-1] != w_op_a[LAST][WIDTH-1]);
    end

    // Overflow flag travels with the final stage so it stays aligned with sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, SEG=8); define PIPELINED_ADDSUB_OVF_EN to also check ovf.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
    logic [31:0] a, b, sum;
`ifdef PIPELINED_ADDSUB_OVF_EN
    logic        ovf;
`endif

    pipelined_addsub #(.WIDTH(32), .SEG(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub);
        exp_t        e;
        logic [32:0] r;
        longint      sr;
        if (msub) begin
            r  = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
            sr = longint'($signed(ma)) - longint'($signed(mb));
        end else begin
            r  = {1'b0, ma} + {1'b0, mb} + {32'd0, mcin};
            sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mcin);
        end
        e.s = r[31:0];
        e.c = r[32];
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    // One cycle: drive at negedge, record accepted txn, report whether a result is consumed at next posedge.
    task automatic tick(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic icin, input logic isub, input logic iordy, output logic took);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c_in      = icin;
        sub       = isub;
        out_ready = iordy;
        #1;
        if (iv && in_ready) q.push_back(model(ia, ib, icin, isub));
        took = out_valid && out_ready;
    endtask

    task automatic test_reset();
        logic t;
        reset = 1'b1;
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, t);
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, t);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else passes++;
        checks++;
        if ({sum, c_out} !== 33'd0) $display("FAIL reset_sum got %h/%b want 0/0", sum, c_out);
        else passes++;
        reset = 1'b0;
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL post_reset got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else passes++;
        q.delete();
    endtask

    task automatic test_vector(input string name, input logic [31:0] va, input logic [31:0] vb,
                               input logic vcin, input logic vsub, input logic [31:0] xs,
                               input logic xc, input logic xo);
        logic t;
        int   lat;
        exp_t e;
        tick(1'b1, va, vb, vcin, vsub, 1'b1, t);
        lat = 0;
        t   = 1'b0;
        while (!t && lat < 12) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
            lat++;
        end
        checks++;
        if (lat !== 4) $display("FAIL %s_latency got %0d want 4", name, lat);
        else passes++;
        checks++;
        if ({sum, c_out} !== {xs, xc})
            $display("FAIL %s_result got %h/%b want %h/%b", name, sum, c_out, xs, xc);
        else passes++;
`ifdef PIPELINED_ADDSUB_OVF_EN
        checks++;
        if (ovf !== xo) $display("FAIL %s_ovf got %b want %b", name, ovf, xo);
        else passes++;
`endif
        if (q.size() > 0) e = q.pop_front();
        checks++;
        if ({e.s, e.c} !== {xs, xc})
            $display("FAIL %s_model got %h/%b want %h/%b", name, e.s, e.c, xs, xc);
        else passes++;
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL %s_one_cycle got valid=%b want 0", name, out_valid);
        else passes++;
        q.delete();
    endtask

    task automatic test_back_to_back();
        logic t;
        exp_t e;
        int   first, last, n;
        first = -1; last = -1; n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 10)
                tick(1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, t);
            else
                tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
            if (t) begin
                if (first < 0) first = i;
                last = i;
                n++;
                checks++;
                if (q.size() == 0) $display("FAIL b2b_unexpected got sum=%h want none", sum);
                else begin
                    e = q.pop_front();
                    if ({sum, c_out} !== {e.s, e.c})
                        $display("FAIL b2b_result got %h/%b want %h/%b", sum, c_out, e.s, e.c);
                    else passes++;
                end
            end
        end
        checks++;
        if (n !== 10 || (last - first) !== 9)
            $display("FAIL b2b_streak got n=%0d span=%0d want 10/9", n, last - first);
        else passes++;
        q.delete();
    endtask

    task automatic test_backpressure();
        logic        t;
        exp_t        e;
        logic [32:0] snap;
        int          n;
        for (int i = 0; i < 4; i++)
            tick(1'b1, 32'h1000_0000 * i + 32'd3, 32'd100 + i, 1'b1, 1'(i % 2), 1'b0, t);
        snap = 33'd0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b0, t);
            if (i == 0) snap = {sum, c_out};
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {sum, c_out} !== snap)
                $display("FAIL stall_frozen got ready=%b valid=%b sum=%h want 0/1/%h",
                         in_ready, out_valid, sum, snap[32:1]);
            else passes++;
        end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
            if (t) begin
                n++;
                checks++;
                if (q.size() == 0) $display("FAIL stall_unexpected got sum=%h want none", sum);
                else begin
                    e = q.pop_front();
                    if ({sum, c_out} !== {e.s, e.c})
                        $display("FAIL stall_result got %h/%b want %h/%b", sum, c_out, e.s, e.c);
                    else passes++;
                end
            end
        end
        checks++;
        if (n !== 4 || q.size() !== 0)
            $display("FAIL stall_drain got %0d delivered, %0d left want 4/0", n, q.size());
        else passes++;
        q.delete();
    endtask

    task automatic test_reset_in_flight();
        logic t;
        int   stale;
        for (int i = 0; i < 3; i++)
            tick(1'b1, 32'd50 + i, 32'd7, 1'b0, 1'b0, 1'b1, t);
        reset = 1'b1;
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
        reset = 1'b0;
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flight_after_reset got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else passes++;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, t);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) $display("FAIL flight_stale got %0d valid cycles want 0", stale);
        else passes++;
        q.delete();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
        c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        test_reset();
        test_vector("add_basic", 32'd15, 32'd1, 1'b0, 1'b0, 32'd16, 1'b0, 1'b0);
        test_vector("carry_chain", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        test_vector("sub_borrow", 32'd1, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0);
        test_vector("sub_cin_ignored", 32'd5, 32'd5, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
        test_vector("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        test_vector("add_ovf", 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
